instruction_fetch_queue: RTL
============================

// Module: instruction_fetch_queue
// PURPOSE
//  Parametrised front-end fetch stage. Holds a loadable instruction memory, keeps a fetch PC,
//  and prefetches {pc, instr} pairs into a small queue. Decode consumes the queue through a
//  valid/ready handshake. Supports branch/jump redirect with flush of stale entries.
//  Sits between the memory-load path from the testbench/boot loader and the decode stage.
// PARAMETERS
//  DATA_W      32   instruction width, bits
//  ADDR_W      32   PC width, bits
//  IMEM_DEPTH  32   instruction memory depth in words (power of 2); IDX_W = $clog2(IMEM_DEPTH)
//  FIFO_DEPTH  4    prefetch queue entries (power of 2, >= 2)
//  RESET_PC    0    fetch PC after reset (word aligned)
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  load_mem_en    in   1       write load_mem_data into imem[load_mem_addr]; suppresses fetch
//  load_mem_addr  in   IDX_W   word index for the load
//  load_mem_data  in   DATA_W  word to load
//  redirect_en    in   1       branch/jump taken: flush queue and refetch from redirect_pc
//  redirect_pc    in   ADDR_W  new fetch PC; bits [1:0] ignored (forced to 00)
//  out_ready      in   1       decode can accept the head entry
//  out_valid      out  1       head entry valid
//  instr          out  DATA_W  head instruction (0 when empty)
//  pc_out         out  ADDR_W  PC of head instruction (0 when empty)
//  q_level        out  $clog2(FIFO_DEPTH)+1  queue occupancy
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, queue empty, in-flight=0, out_valid=0, instr=0, pc_out=0,
//   q_level=0. Memory contents are not reset.
//  Memory: synchronous read, 1-cycle latency. Read index = fetch_pc[IDX_W+1:2]. PC keeps
//   incrementing by 4, so the index wraps modulo IMEM_DEPTH. Load writes take effect at the
//   clock edge. A read issued the cycle after a load returns the new data.
//  Issue: in cycle N, a read of fetch_pc is issued, and fetch_pc += 4, when all of these hold:
//   !load_mem_en, !redirect_en, and q_level + inflight < FIFO_DEPTH. This is credit-based, so the
//   queue never overflows. In cycle N+1 the {pc, data} pair is pushed. out_valid rises in
//   cycle N+2. At most one read is in flight at a time.
//  Throughput: 1 instr/cycle sustained when out_ready=1. First out_valid is 2 cycles after rst_n
//   deasserts.
//  Handshake: transfer occurs when out_valid && out_ready. instr/pc_out are stable while
//   out_valid && !out_ready. Push and pop in the same cycle keep q_level unchanged.
//  Redirect (cycle R): a head transfer in cycle R is honoured. All other entries are flushed and
//   the in-flight read is killed (not pushed). fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
//   Issue resumes in R+1, and the first redirected instr is valid in R+3. out_valid=0 in R+1
//   and R+2.
//  redirect_en with load_mem_en in the same cycle: the redirect is applied, and fetch stays
//   suppressed until load_mem_en drops.
//  load_mem_en high: no new issues. The queue keeps draining, and a read already in flight is
//   still pushed. Entries already queued are NOT invalidated by loads. Software must redirect
//   after reloading.
//  Empty: out_valid=0 and outputs are 0. Full: issue is blocked by the credit rule above.
//  Reset mid-operation: all state returns to its reset values immediately, and in-flight data
//   is discarded.
// STRUCTURE
//  Shared package ifetch_pkg holds the RESET_PC default, PC increment constant (4), and the
//   fetch_entry_t {pc, instr} packing width/offsets, shared with the decode stage.
//  One sub-module, ifq_fifo: a synchronous FIFO with a flush input and a level output, holding
//   ADDR_W+DATA_W bits per entry.
//  Top level holds the imem array, the fetch PC, the in-flight flag/pc register, and the
//   issue/credit logic.
// TESTING
//  1 Load imem[i]=i*0x11 for i=0..31, then run with out_ready=1 -> pc_out 0,4,...,0x7C with
//    matching instr, one per cycle. Then pc 0x80 returns imem[0] (wrap).
//  2 Hold out_ready=0 for 10 cycles mid-stream -> q_level saturates at 4, instr/pc_out frozen.
//    After release, the sequence continues with no gap or duplicate.
//  3 Redirect to 0x40 while the queue is full -> stale entries never appear. out_valid=0 for
//    2 cycles, then pc_out=0x40, instr=imem[16].
//  4 Redirect to 0x43 with load_mem_en=1 -> no output until the load drops. Next pc_out=0x40.
//  5 Reload imem[5]=0xDEADBEEF, then redirect to 0x14 -> instr=0xDEADBEEF, pc_out=0x14.
//  6 Assert rst_n=0 asynchronously mid-stream -> out_valid=0, q_level=0 immediately. After
//    release, pc_out=RESET_PC 2 cycles later.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared fetch-stage constants and the {pc, instr} entry layout used by fetch and decode.
package ifetch_pkg;

  localparam int unsigned DefDataW       = 32;
  localparam int unsigned DefAddrW       = 32;
  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
  localparam int unsigned PcInc          = 4;

  // Entry packing: pc in the upper bits, instr in the lower bits.
  typedef struct packed {
    logic [DefAddrW-1:0] pc;
    logic [DefDataW-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned FetchEntryW   = $bits(fetch_entry_t);
  localparam int unsigned EntryInstrLsb = 0;
  localparam int unsigned EntryPcLsb    = DefDataW;

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-to-decode handshake: the fetch queue is the master, decode is the slave.
interface instruction_fetch_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LVL_W  = 3
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] pc_out;
  logic [LVL_W-1:0]  q_level;

  modport master (
    output out_valid,
    output instr,
    output pc_out,
    output q_level,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  instr,
    input  pc_out,
    input  q_level,
    output out_ready
  );
endinterface

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush and occupancy output; read data is the current head entry.
module ifq_fifo #(
  parameter int unsigned  WIDTH = 64,
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] level_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  assign push_en = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_en  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign level_o = count_q;
endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: loadable imem, fetch PC, one-deep in-flight read and a credit-limited prefetch queue.
module instruction_fetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned       DATA_W     = DefDataW,
  parameter int unsigned       ADDR_W     = DefAddrW,
  parameter int unsigned       IMEM_DEPTH = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(ResetPcDefault),
  localparam int unsigned      IDX_W      = $clog2(IMEM_DEPTH),
  localparam int unsigned      LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_mem_en,
  input  logic [IDX_W-1:0]  load_mem_addr,
  input  logic [DATA_W-1:0] load_mem_data,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  instruction_fetch_queue_if.master dq
);
  localparam int unsigned    EntryW  = ADDR_W + DATA_W;
  localparam logic [LVL_W:0] Credits = (LVL_W + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] imem [IMEM_DEPTH];
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;
  logic [DATA_W-1:0] rdata_q;
  logic [IDX_W-1:0]  rd_idx;
  logic              issue, push, pop;
  logic              head_valid;
  logic [LVL_W-1:0]  level;
  logic [EntryW-1:0] head;
  logic              unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign rd_idx = fetch_pc_q[IDX_W+1:2];

  // Queued entries plus the in-flight read must fit, so a push can never hit a full queue.
  assign issue = !load_mem_en && !redirect_en &&
                 (({1'b0, level} + {{LVL_W{1'b0}}, inflight_q}) < Credits);
  // A redirect kills the read returning this cycle.
  assign push  = inflight_q && !redirect_en;
  assign pop   = head_valid && dq.out_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_en) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PcInc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= fetch_pc_q;
    end
  end

  // Memory contents survive reset; loads and issues never share a cycle.
  always_ff @(posedge clk) begin
    if (load_mem_en) imem[load_mem_addr] <= load_mem_data;
    if (issue)       rdata_q <= imem[rd_idx];
  end

  ifq_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (redirect_en),
    .push_i  (push),
    .wdata_i ({inflight_pc_q, rdata_q}),
    .pop_i   (pop),
    .rdata_o (head),
    .valid_o (head_valid),
    .level_o (level)
  );

  assign dq.out_valid = head_valid;
  assign dq.instr     = head_valid ? head[DATA_W-1:0] : '0;
  assign dq.pc_out    = head_valid ? head[DATA_W +: ADDR_W] : '0;
  assign dq.q_level   = level;
endmodule
